// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: issues word-aligned fetch requests
// against a variable-latency in-order instruction memory, buffers returned
// instructions with their PCs in a small circular queue, and handles
// redirects by flushing the queue and discarding stale in-flight responses.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            flush_pending
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [XLEN-1:0] r_q_pc   [QDEPTH];
    logic [31:0]     r_q_data [QDEPTH];

    logic [CW:0]     w_credit_sum;
    logic            w_has_credit;
    logic            w_req_fire;
    logic            w_keep;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_out_after_rsp;

    // Credit covers both in-flight requests and queued entries, so a
    // response always finds a free slot and the queue cannot overflow.
    assign w_credit_sum    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_has_credit    = (w_credit_sum < (CW+1)'(QDEPTH));
    assign imem_req_valid  = reset && !redirect_valid && w_has_credit;
    assign imem_req_addr   = r_fetch_pc;
    assign w_req_fire      = imem_req_valid && imem_req_ready;
    assign w_keep          = imem_rsp_valid && (r_drop_cnt == '0);
    assign w_pop           = (r_count != '0) && inst_ready;
    assign w_redirect_pc   = redirect_pc & ~XLEN'(3);
    assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);

    // Outputs are masked during the reset cycle so nothing downstream acts on
    // state that is about to be discarded.
    assign inst_valid      = reset && (r_count != '0);
    assign inst_data       = r_q_data[r_head];
    assign inst_pc         = r_q_pc[r_head];
    assign flush_pending   = reset && (r_drop_cnt != '0);

    // Control state: PCs, credit counters, queue pointers; redirect overrides all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else if (redirect_valid) begin
            // Every request still unanswered after this cycle is stale.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= w_out_after_rsp;
            r_drop_cnt    <= w_out_after_rsp;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_keep) begin
                r_tail   <= r_tail + PW'(1);
                r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_keep) - CW'(w_pop);
        end
    end

    // Queue storage: written on a kept response, never reset.
    always_ff @(posedge clk) begin
        if (reset && !redirect_valid && w_keep) begin
            r_q_pc[r_tail]   <= r_rsp_pc;
            r_q_data[r_tail] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency in-order memory model,
// a queue-level reference of the instruction buffer, and a sequential PC
// stream expectation restarted by every reset and redirect.
module tb_fetch_unit;

    localparam int          QDEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        flush_pending;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .flush_pending  (flush_pending)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } qent_t;

    mreq_t       mq[$];
    qent_t       iq[$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_stream;
    int          cyc = 0;
    int          n_pop = 0;
    int          n_chk = 0;
    int          n_err = 0;

    int          p_mready = 100;
    int          p_iready = 100;
    int          p_redir  = 0;
    int          p_reset  = 0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    bit          f_redir  = 0;
    logic [31:0] f_pc     = '0;
    bit          f_reset  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h0013_0013;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit          d_rst, d_redir, d_mready, d_iready, d_rspv, exp_rv, fire, pop;
        logic [31:0] d_rpc;
        mreq_t       m;
        qent_t       e;
        @(negedge clk);
        d_rst    = !(f_reset || ($urandom_range(999) < p_reset));
        d_redir  = d_rst && (f_redir || ($urandom_range(99) < p_redir));
        d_rpc    = f_redir ? f_pc : $urandom();
        f_redir  = 0;
        f_reset  = 0;
        d_mready = ($urandom_range(99) < p_mready);
        d_iready = ($urandom_range(99) < p_iready);
        d_rspv   = d_rst && (mq.size() != 0) && (mq[0].due <= cyc);
        reset          = d_rst;
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        imem_req_ready = d_mready;
        inst_ready     = d_iready;
        imem_rsp_valid = d_rspv;
        imem_rsp_data  = d_rspv ? mem_word(mq[0].addr) : $urandom();
        #1;
        exp_rv = d_rst && !d_redir && ((mq.size() + iq.size()) < QDEPTH);
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv});
        if (exp_rv) check("req_addr", {32'd0, imem_req_addr}, {32'd0, exp_fetch});
        check("inst_valid", {63'd0, inst_valid}, {63'd0, d_rst && (iq.size() != 0)});
        if (d_rst && iq.size() != 0) begin
            check("inst_pc", {32'd0, inst_pc}, {32'd0, iq[0].pc});
            check("inst_data", {32'd0, inst_data}, {32'd0, iq[0].data});
            check("stream_pc", {32'd0, inst_pc}, {32'd0, exp_stream});
        end
        check("flush_pending", {63'd0, flush_pending}, {63'd0, d_rst && (stale_cnt() != 0)});
        fire = exp_rv && d_mready;
        pop  = d_rst && (iq.size() != 0) && d_iready;
        @(posedge clk);
        if (!d_rst) begin
            mq.delete();
            iq.delete();
            exp_fetch  = RST_PC;
            exp_stream = RST_PC;
        end else if (d_redir) begin
            if (d_rspv) void'(mq.pop_front());
            foreach (mq[i]) mq[i].stale = 1;
            iq.delete();
            exp_fetch  = {d_rpc[31:2], 2'b00};
            exp_stream = {d_rpc[31:2], 2'b00};
            if (pop) n_pop++;
        end else begin
            if (pop) begin
                void'(iq.pop_front());
                exp_stream = exp_stream + 32'd4;
                n_pop++;
            end
            if (d_rspv) begin
                m = mq.pop_front();
                if (!m.stale) begin
                    e.pc   = m.addr;
                    e.data = mem_word(m.addr);
                    iq.push_back(e);
                end
            end
            if (fire) begin
                m.addr  = exp_fetch;
                m.due   = cyc + $urandom_range(lat_hi, lat_lo);
                m.stale = 0;
                mq.push_back(m);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int pops_before;

    initial begin
        reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        exp_fetch = RST_PC; exp_stream = RST_PC;

        // Reset, then 1-cycle memory with decode always ready.
        f_reset = 1; step();
        f_reset = 1; step();
        run(6);
        pops_before = n_pop;
        run(10);
        check("throughput", 64'(n_pop - pops_before), 64'd10);

        // Decode stalls: queue fills, requests stop, then drain resumes.
        p_iready = 0; run(12);
        p_iready = 100; run(10);

        // 3-cycle memory, redirect to an unaligned target with requests in flight.
        lat_lo = 3; lat_hi = 3;
        run(6);
        f_redir = 1; f_pc = 32'h0000_0103; step();
        run(15);

        // Redirect across the top of the address space.
        lat_lo = 1; lat_hi = 1;
        f_redir = 1; f_pc = 32'hFFFF_FFF4; step();
        run(12);

        // Reset mid-stream with a partly filled queue.
        p_iready = 0; run(4);
        f_reset = 1; step();
        p_iready = 100; run(8);

        // Randomized traffic: variable latency, backpressure, redirects, resets.
        lat_lo = 1; lat_hi = 4; p_mready = 70; p_iready = 60; p_redir = 4; p_reset = 5;
        run(2500);
        p_redir = 0; p_reset = 0; p_mready = 100; p_iready = 100;
        run(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Decoupled instruction-fetch front end for the RV32I core.
- Replaces the combinational PC → instruction_mem → decode path with a request/response fetch engine.
- Tolerates variable-latency, in-order instruction memory; buffers fetched instructions with their PCs in a QDEPTH-entry queue.
- Accepts branch/jump redirects from execute: flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QDEPTH, 4, instruction queue entries; power of two, ≥2. Also caps requests in flight plus queued entries.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset (0 at posedge = reset).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; always accepted, in request order.
- imem_rsp_data  input  32  fetched instruction word.
- redirect_valid  input  1  redirect fetch stream this cycle.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (forced 0).
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode consumes head.
- inst_data  output  32  head instruction.
- inst_pc  output  XLEN  head PC.
- flush_pending  output  1  stale responses still being discarded.

Behaviour:
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of next kept response.
  - outstanding: requests accepted but not yet answered; width clog2(QDEPTH)+1.
  - drop_cnt: responses still to be discarded; same width.
  - Circular queue of {pc, instr} with head/tail pointers and count.
- Reset (reset==0 at posedge):
  - fetch_pc = rsp_pc = RESET_PC; outstanding = drop_cnt = count = 0.
  - Outputs during and after the reset cycle: inst_valid=0, imem_req_valid=0, flush_pending=0.
  - Reset mid-transaction abandons all in-flight requests. Memory must also be reset; no responses may be generated for abandoned requests.
- Credit:
  - imem_req_valid = reset && !redirect_valid && (outstanding + count < QDEPTH).
  - imem_req_addr = fetch_pc.
  - Queue overflow is impossible by construction.
- Request handshake (imem_req_valid && imem_req_ready): fetch_pc += 4 (mod 2^XLEN wrap); outstanding += 1.
- Response (imem_rsp_valid), always: outstanding -= 1.
  - If drop_cnt != 0: discard; drop_cnt -= 1.
  - Else: push {rsp_pc, imem_rsp_data} at tail; rsp_pc += 4.
- Output:
  - inst_valid = (count != 0).
  - inst_data/inst_pc = head entry, registered.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle: count unchanged.
- Latency: response at edge N is visible on inst_valid after edge N. With a 1-cycle memory and inst_ready held high, throughput is one instruction per cycle.
- Redirect (redirect_valid at posedge) has priority over all other updates:
  - Queue cleared (count=0, head=tail).
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued this cycle (req_valid gated).
  - A response arriving this cycle is discarded.
  - outstanding_next = outstanding − imem_rsp_valid; drop_cnt_next = outstanding_next.
  - An inst handshake in the redirect cycle counts as consumed; the queue is still cleared.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- New requests may issue while drop_cnt != 0. Memory ordering guarantees stale responses arrive first.
- flush_pending = (drop_cnt != 0).
- Idle (queue full, no consumption): req_valid=0, all state held.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 → requests 0x0,0x4,0x8…, one per cycle after first fill; inst_pc sequence 0x0,0x4,0x8 with matching memory words.
- inst_ready=0, QDEPTH=4 → exactly 4 requests issued, then req_valid=0 and queue holds 0x0–0xC. Raise ready → drains in order, fetch resumes at 0x10.
- 3-cycle latency, 2 requests in flight (0x20,0x24), redirect_pc=0x103 → flush_pending=1; next request addr 0x100; both stale responses dropped; first inst_pc=0x100.
- Redirect in same cycle as response for 0x8 with outstanding=1 → response discarded, drop_cnt=0, no req that cycle; next cycle req addr = redirect target.
- Assert reset mid-stream with queue count=3 → next cycle inst_valid=0, req_valid=0. On release, first req addr = RESET_PC.
- fetch_pc=0xFFFF_FFFC, request accepted → next req addr 0x0000_0000 (wrap); inst_pc of that entry = 0x0.
